// File: rtl/bht_upd_queue.sv
// Branch-history update queue: in-order FIFO of predicted branches that drives
// the history table's update port as branches resolve, discarding wrong-path entries.
module bht_upd_queue #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [ADDR_W-1:0] alloc_addr,
  input  logic              alloc_pred,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic              flush,
  output logic              up_en,
  output logic [ADDR_W-1:0] up_addr,
  output logic              wr_data,
  output logic              mispredict,
  output logic              res_err,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic              pred_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic              pop;
  logic              push;
  logic              head_mis;
  logic              discard;
  logic [PTR_W:0]    count_next;

  assign alloc_ready = (count != FULL_CNT);

  always_comb begin
    pop        = res_valid && (count != '0);
    head_mis   = pop && (pred_mem[rd_ptr] != res_taken);
    discard    = flush || head_mis;
    // A same-cycle alloc during a discard is wrong-path and never stored.
    push       = alloc_valid && alloc_ready && !discard;
    count_next = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= alloc_addr;
      pred_mem[wr_ptr] <= alloc_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      up_en      <= 1'b0;
      up_addr    <= '0;
      wr_data    <= 1'b0;
      mispredict <= 1'b0;
      res_err    <= 1'b0;
    end else begin
      up_en      <= pop;
      mispredict <= head_mis;
      res_err    <= res_valid && (count == '0);
      if (pop) begin
        up_addr <= addr_mem[rd_ptr];
        wr_data <= res_taken;
      end
      if (discard) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push) wr_ptr <= wr_ptr + 1'b1;
        count <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_bht_upd_queue.sv
// Self-checking bench for bht_upd_queue: directed scenarios then random traffic,
// compared against a queue-based reference model.
module tb_bht_upd_queue;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [ADDR_W-1:0] alloc_addr;
  logic              alloc_pred;
  logic              res_valid;
  logic              res_taken;
  logic              flush;
  logic              up_en;
  logic [ADDR_W-1:0] up_addr;
  logic              wr_data;
  logic              mispredict;
  logic              res_err;
  logic [PTR_W:0]    count;

  bht_upd_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_addr(alloc_addr), .alloc_pred(alloc_pred),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .up_en(up_en), .up_addr(up_addr), .wr_data(wr_data),
    .mispredict(mispredict), .res_err(res_err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              pred;
  } ent_t;

  ent_t              mq[$];
  logic [ADDR_W-1:0] m_addr;
  logic              m_wr;
  logic              e_en, e_mis, e_err;
  int                checks = 0;
  int                errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("up_en", 32'(up_en), 32'(e_en));
    chk("up_addr", 32'(up_addr), 32'(m_addr));
    chk("wr_data", 32'(wr_data), 32'(m_wr));
    chk("mispredict", 32'(mispredict), 32'(e_mis));
    chk("res_err", 32'(res_err), 32'(e_err));
    chk("count", 32'(count), mq.size());
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
  endtask

  // One clock: drive inputs, update the model by the queue rules, check after the edge.
  task automatic cyc(input logic av, input logic [ADDR_W-1:0] aa, input logic ap,
                     input logic rv, input logic rt, input logic fl);
    bit full, pop, discard;
    ent_t head;
    alloc_valid = av; alloc_addr = aa; alloc_pred = ap;
    res_valid = rv; res_taken = rt; flush = fl;
    full  = (mq.size() == DEPTH);
    pop   = rv && (mq.size() != 0);
    e_en  = pop;
    e_err = rv && (mq.size() == 0);
    e_mis = 1'b0;
    if (pop) begin
      head   = mq.pop_front();
      m_addr = head.addr;
      m_wr   = rt;
      e_mis  = (head.pred != rt);
    end
    discard = fl || e_mis;
    if (discard) mq.delete();
    if (av && !full && !discard) mq.push_back('{addr: aa, pred: ap});
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic do_reset(input logic rv);
    alloc_valid = 1'b1; alloc_addr = 10'h1AB; alloc_pred = 1'b1;
    res_valid = rv; res_taken = 1'b0; flush = 1'b0;
    reset = 1'b1;
    mq.delete();
    m_addr = '0; m_wr = 1'b0; e_en = 1'b0; e_mis = 1'b0; e_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check_outputs();
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    do_reset(1'b0);

    // In-order update
    cyc(1'b1, 10'h005, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Fill, ignored 9th alloc, then wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 10'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_count", 32'(count), 32'd8);
    cyc(1'b1, 10'h0FF, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h0FE, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 8; i < 11; i++) cyc(1'b1, 10'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("wrap_last_addr", 32'(up_addr), 32'd10);
    idle();

    // Mispredict discard with same-cycle alloc
    cyc(1'b1, 10'h010, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h011, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h012, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 10'h013, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mis_pulse", 32'(mispredict), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("mis_then_err", 32'(res_err), 32'd1);

    // Flush with resolve
    for (int i = 0; i < 4; i++) cyc(1'b1, 10'(32'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("flush_head_addr", 32'(up_addr), 32'h40);
    idle();

    // Empty resolve with alloc
    cyc(1'b1, 10'h020, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("empty_err", 32'(res_err), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("empty_next_addr", 32'(up_addr), 32'h20);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) cyc(1'b1, 10'(32'h50 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset(1'b1);

    // Random traffic, biased towards correct predictions so the queue fills
    for (int n = 0; n < 600; n++) begin
      logic rt;
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        rt = 1'($urandom_range(0, 1));
        if (mq.size() != 0 && $urandom_range(0, 9) != 0) rt = mq[0].pred;
        cyc(($urandom_range(0, 9) < 6), 10'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 4), rt, ($urandom_range(0, 49) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bht_upd_queue.md
# bht_upd_queue

Branch-history update queue: the writer side of the branch history table. It records each predicted branch at fetch time in an in-order FIFO. As branches resolve oldest-first, it drives the table's update port (up_en / up_addr / wr_data) with the actual outcome. It also detects mispredictions and discards wrong-path entries. It sits between the fetch/predict stage and the branch resolution unit, and its update outputs connect directly to the history table's update inputs.

## Interface
Parameters:
- ADDR_W, 10, width of the history-table index (matches the table's address width)
- DEPTH, 8, number of in-flight branch entries; power of two, ≥2
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- alloc_valid  input  1  fetch stage presents a predicted branch
- alloc_ready  output  1  queue can accept; combinational, equals (count != DEPTH)
- alloc_addr  input  ADDR_W  history-table index of the branch
- alloc_pred  input  1  predicted direction (1 = taken)
- res_valid  input  1  oldest in-flight branch has resolved this cycle
- res_taken  input  1  actual direction of that branch
- flush  input  1  external pipeline flush; discards all in-flight entries
- up_en  output  1  registered; one-cycle update strobe to the history table
- up_addr  output  ADDR_W  registered; table index to update
- wr_data  output  1  registered; outcome bit shifted into the history
- mispredict  output  1  registered; one-cycle pulse, resolved outcome != prediction
- res_err  output  1  registered; one-cycle pulse, res_valid received while queue empty
- count  output  PTR_W+1  registered; number of valid entries

## Operation
- Storage: DEPTH entries of {addr, pred}, with head pointer (rd_ptr), tail pointer (wr_ptr) and count. Pointers wrap modulo DEPTH.
- Alloc: when alloc_valid && alloc_ready and the cycle is not discarding, write {alloc_addr, alloc_pred} at wr_ptr, then increment wr_ptr.
- Resolve with count != 0:
  - pop the head entry;
  - next cycle, up_en=1, up_addr=head.addr, wr_data=res_taken, mispredict=(head.pred != res_taken).
- Resolve with count == 0: no update; res_err=1 next cycle. Any alloc in the same cycle is still accepted, and res does not consume it.
- Discard condition: flush, or a popped entry that mispredicts.
  - On discard, rd_ptr, wr_ptr and count go to 0 at the edge.
  - An alloc in the same cycle is dropped (treated as wrong-path).
  - The resolving entry's update is still issued.
- Simultaneous alloc and resolve without discard: count is unchanged, both pointers advance.
- Full: alloc_ready=0, and alloc_valid is ignored. There is no bypass, so a resolve in the same cycle does not raise alloc_ready in that cycle.
- Count arithmetic: count_next = count + push − pop, unsigned, width PTR_W+1, never exceeds DEPTH. Discard overrides it to 0.
- Reset mid-operation: all entries are invalidated and outputs return to reset values on the next edge. Any pending update is lost; the table itself is reset by the same signal.

## Timing
- Reset values: up_en=0, up_addr=0, wr_data=0, mispredict=0, res_err=0, count=0; alloc_ready=1 after reset.
- Latency: res_valid at edge N produces up_en, up_addr, wr_data and mispredict valid during cycle N+1, for exactly one cycle unless another resolve follows.
- Throughput: one alloc and one resolve per cycle; back-to-back resolves give back-to-back up_en pulses.
- Read-after-write: an entry allocated at edge N can be resolved at edge N+1 at the earliest.
- up_addr and wr_data hold their last values when up_en=0.
- count and alloc_ready reflect the discard from the cycle after the discarding edge.

## Test plan
- **In-order update.** After reset, alloc addr 0x005 pred 1, then 0x3FF pred 0; resolve taken=1, then taken=0 on consecutive cycles. Required: up_en high two cycles, up_addr 0x005 then 0x3FF, wr_data 1 then 0, mispredict 0, count ends at 0.
- **Fill and wrap.** Alloc 8 entries with addr 0..7: alloc_ready=0 and count=8, and a 9th alloc is ignored. Resolve 3, alloc 3 more (addr 8..10, wrapping the pointers), then resolve all. Required: up_addr sequence 0..7, 8, 9, 10 with no loss.
- **Mispredict discard.** Queue holds 0x010 pred 1, 0x011, 0x012; resolve with taken=0, with a simultaneous alloc of 0x013. Required next cycle: up_en=1, up_addr=0x010, wr_data=0, mispredict=1, count=0. 0x013 is not stored, and a subsequent resolve gives res_err=1.
- **Flush with resolve.** Queue holds 4 entries; flush=1 and res_valid=1 in the same cycle. Required: one update for the head entry, then count=0 and alloc_ready=1.
- **Empty resolve with alloc.** Queue empty; res_valid=1 with alloc 0x020. Required: res_err=1, up_en=0, count=1. The next resolve updates 0x020.
- **Reset mid-operation.** With 5 entries held and a resolve pending, assert reset for one cycle. Required: all outputs at reset values the next cycle, count=0, alloc_ready=1.
